// File: rtl/transmit_code_group.sv
// 1000BASE-X PCS transmit code-group stage.
// Turns the ordered set requested by the upstream TX ordered-set FSM into one
// 8b/10b code-group per GTX_CLK. It tracks running disparity, picks /I1/ or /I2/
// from that disparity, and alternates /C1/ and /C2/.
// Ordered-set encodings (tx_o_set): C=01 I=02 R=04 S=08 T=10 V=20 D=40 (hex).
// Any other value is sent as /V/.
module transmit_code_group (
    input  logic        GTX_CLK,
    input  logic        mr_main_reset,
    input  logic [6:0]  tx_o_set,
    input  logic [7:0]  TXD,
    input  logic [15:0] tx_config_reg,
    output logic [9:0]  tx_code_group,
    output logic        tx_even,
    output logic        TX_OSET_indicate,
    output logic        tx_disparity
);

    localparam logic [6:0] TX_OS_C = 7'h01;
    localparam logic [6:0] TX_OS_I = 7'h02;
    localparam logic [6:0] TX_OS_R = 7'h04;
    localparam logic [6:0] TX_OS_S = 7'h08;
    localparam logic [6:0] TX_OS_T = 7'h10;
    localparam logic [6:0] TX_OS_V = 7'h20;
    localparam logic [6:0] TX_OS_D = 7'h40;

    // Special code-groups, abcdei_fghj, for the RD- and RD+ columns.
    localparam logic [9:0] K28_5_N = 10'b001111_1010;
    localparam logic [9:0] K28_5_P = 10'b110000_0101;
    localparam logic [9:0] K23_7_N = 10'b111010_1000;
    localparam logic [9:0] K23_7_P = 10'b000101_0111;
    localparam logic [9:0] K27_7_N = 10'b110110_1000;
    localparam logic [9:0] K27_7_P = 10'b001001_0111;
    localparam logic [9:0] K29_7_N = 10'b101110_1000;
    localparam logic [9:0] K29_7_P = 10'b010001_0111;
    localparam logic [9:0] K30_7_N = 10'b011110_1000;
    localparam logic [9:0] K30_7_P = 10'b100001_0111;

    // Octets of the fixed data code-groups used inside /I/ and /C/.
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;

    // The /I/ test of the disparity happens on the dispatch edge, so the
    // IDLE_1 group is emitted on that same edge.
    typedef enum logic [3:0] {
        GENERATE, SPECIAL_GO, DATA_GO, IDLE_1, IDLE_2,
        CONF_A, CONF_B, CONF_C, CONF_D
    } state_t;

    state_t      state;
    state_t      sel_state;
    logic [9:0]  grp;
    logic [15:0] cfg_q;
    logic        idle_rd_plus;
    logic        conf_c2;

    function automatic logic [3:0] ones_count(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    // 5b/6b: the table holds the RD- column. The RD+ column is the complement,
    // except for balanced groups, which are the same in both columns. D.7 is
    // balanced but is still complemented.
    function automatic logic [5:0] enc_6b(input logic [4:0] x, input logic rd);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;  5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;  5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;  5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;  default: c = 6'b101011;
        endcase
        if (rd && (ones_count({4'd0, c}) != 4'd3 || x == 5'd7)) c = ~c;
        return c;
    endfunction

    // 3b/4b: the RD+ column is the complement of the RD- column, except for
    // balanced groups. x.3 is balanced but is still complemented.
    // A7 replaces P7 where P7 would produce a run of five identical bits.
    function automatic logic [3:0] enc_4b(input logic [2:0] y, input logic rd6,
                                          input logic alt);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;  3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;  3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;  default: c = alt ? 4'b0111 : 4'b1110;
        endcase
        if (rd6 && (ones_count({6'd0, c}) != 4'd2 || y == 3'd3 || y == 3'd7)) c = ~c;
        return c;
    endfunction

    function automatic logic [9:0] enc_data(input logic [7:0] d, input logic rd);
        logic [5:0] six;
        logic       rd6;
        logic       alt;
        six = enc_6b(d[4:0], rd);
        rd6 = (ones_count({4'd0, six}) == 4'd3) ? rd : ~rd;
        alt = (!rd6 && (d[4:0] == 5'd17 || d[4:0] == 5'd18 || d[4:0] == 5'd20)) ||
              ( rd6 && (d[4:0] == 5'd11 || d[4:0] == 5'd13 || d[4:0] == 5'd14));
        return {six, enc_4b(d[7:5], rd6, alt)};
    endfunction

    // Pick the step being emitted this edge, and the code-group it produces.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        sel_state = GENERATE;
        grp       = 10'h000;
        if (TX_OSET_indicate) begin
            case (tx_o_set)
                TX_OS_I: sel_state = IDLE_1;
                TX_OS_C: sel_state = CONF_A;
                TX_OS_D: sel_state = DATA_GO;
                default: sel_state = SPECIAL_GO;
            endcase
        end else begin
            case (state)
                IDLE_1:  sel_state = IDLE_2;
                CONF_A:  sel_state = CONF_B;
                CONF_B:  sel_state = CONF_C;
                CONF_C:  sel_state = CONF_D;
                default: sel_state = GENERATE;
            endcase
        end
        case (sel_state)
            SPECIAL_GO: begin
                case (tx_o_set)
                    TX_OS_S: grp = tx_disparity ? K27_7_P : K27_7_N;
                    TX_OS_T: grp = tx_disparity ? K29_7_P : K29_7_N;
                    TX_OS_R: grp = tx_disparity ? K23_7_P : K23_7_N;
                    default: grp = tx_disparity ? K30_7_P : K30_7_N;
                endcase
            end
            DATA_GO:        grp = enc_data(TXD, tx_disparity);
            IDLE_1, CONF_A: grp = tx_disparity ? K28_5_P : K28_5_N;
            IDLE_2:         grp = enc_data(idle_rd_plus ? D5_6 : D16_2, tx_disparity);
            CONF_B:         grp = enc_data(conf_c2 ? D2_2 : D21_5, tx_disparity);
            CONF_C:         grp = enc_data(cfg_q[7:0], tx_disparity);
            CONF_D:         grp = enc_data(cfg_q[15:8], tx_disparity);
            default:        grp = 10'h000;
        endcase
    end

    // Ordered-set sequencer: register the state, the code-group and the status outputs.
    always_ff @(posedge GTX_CLK) begin
        if (!mr_main_reset) begin
            state            <= GENERATE;
            tx_code_group    <= 10'h000;
            tx_even          <= 1'b0;
            tx_disparity     <= 1'b0;
            TX_OSET_indicate <= 1'b1;
            cfg_q            <= 16'h0000;
            idle_rd_plus     <= 1'b0;
            conf_c2          <= 1'b0;
        end else begin
            // NOTE: use non-blocking assignments so every register samples pre-edge values.
            state            <= sel_state;
            tx_code_group    <= grp;
            tx_even          <= ~tx_even;
            tx_disparity     <= tx_disparity ^ (ones_count(grp) != 4'd5);
            TX_OSET_indicate <= !(sel_state inside {IDLE_1, CONF_A, CONF_B, CONF_C});
            if (sel_state == IDLE_1) idle_rd_plus <= tx_disparity;
            if (sel_state == CONF_A) cfg_q <= tx_config_reg;
            if (sel_state == CONF_D) conf_c2 <= ~conf_c2;
        end
    end

endmodule

// File: tb/tb_transmit_code_group.sv
// Directed, table-driven bench for transmit_code_group. Each row gives the
// inputs for one GTX_CLK and the hand-computed code-group, indicate and
// running disparity. tx_even is tracked alongside (cleared by reset, toggled
// every cycle after reset).
module tb_transmit_code_group;

    localparam logic [6:0] OS_C = 7'h01;
    localparam logic [6:0] OS_I = 7'h02;
    localparam logic [6:0] OS_R = 7'h04;
    localparam logic [6:0] OS_S = 7'h08;
    localparam logic [6:0] OS_T = 7'h10;
    localparam logic [6:0] OS_V = 7'h20;
    localparam logic [6:0] OS_D = 7'h40;
    localparam logic [15:0] CFG = 16'h01A0;

    typedef struct {
        logic        rst_n;
        logic [6:0]  os;
        logic [7:0]  txd;
        logic [15:0] cfg;
        logic [9:0]  grp;
        logic        ind;
        logic        rd;
    } vec_t;

    logic        GTX_CLK = 1'b0;
    logic        mr_main_reset;
    logic [6:0]  tx_o_set;
    logic [7:0]  TXD;
    logic [15:0] tx_config_reg;
    logic [9:0]  tx_code_group;
    logic        tx_even;
    logic        TX_OSET_indicate;
    logic        tx_disparity;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_even = 1'b0;
    vec_t vecs[$];

    transmit_code_group dut (
        .GTX_CLK          (GTX_CLK),
        .mr_main_reset    (mr_main_reset),
        .tx_o_set         (tx_o_set),
        .TXD              (TXD),
        .tx_config_reg    (tx_config_reg),
        .tx_code_group    (tx_code_group),
        .tx_even          (tx_even),
        .TX_OSET_indicate (TX_OSET_indicate),
        .tx_disparity     (tx_disparity)
    );

    always #5 GTX_CLK = ~GTX_CLK;

    function automatic vec_t mk(input logic rst_n, input logic [6:0] os,
                                input logic [7:0] txd, input logic [15:0] cfg,
                                input logic [9:0] grp, input logic ind,
                                input logic rd);
        vec_t v;
        v.rst_n = rst_n; v.os = os; v.txd = txd; v.cfg = cfg;
        v.grp = grp; v.ind = ind; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [12:0] got,
                         input logic [12:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got grp=%h even=%b ind=%b rd=%b, expected grp=%h even=%b ind=%b rd=%b",
                     name, got[12:3], got[2], got[1], got[0],
                     exp[12:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one row between edges, then sample just after the next rising edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge GTX_CLK);
        mr_main_reset = v.rst_n;
        tx_o_set      = v.os;
        TXD           = v.txd;
        tx_config_reg = v.cfg;
        @(posedge GTX_CLK);
        #1;
        exp_even = v.rst_n ? ~exp_even : 1'b0;
        check(name, {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity},
              {v.grp, exp_even, v.ind, v.rd});
    endtask

    initial begin
        mr_main_reset = 1'b0;
        tx_o_set      = OS_I;
        TXD           = 8'h00;
        tx_config_reg = 16'h0000;

        // Reset state
        vecs.push_back(mk(0, OS_I, 8'h00, 16'h0, 10'h000, 1, 0));
        vecs.push_back(mk(0, OS_I, 8'h00, 16'h0, 10'h000, 1, 0));
        // /I/ from RD-: K28.5-, then D16.2 at RD+ (100100_0101), so /I2/
        vecs.push_back(mk(1, OS_I, 8'h00, 16'h0, 10'h0FA, 0, 1));
        vecs.push_back(mk(1, OS_I, 8'h00, 16'h0, 10'h245, 1, 0));
        vecs.push_back(mk(1, OS_I, 8'h00, 16'h0, 10'h0FA, 0, 1));
        vecs.push_back(mk(1, OS_I, 8'h00, 16'h0, 10'h245, 1, 0));
        // D3.0 moves RD to RD+, then /I1/: K28.5+, D5.6
        vecs.push_back(mk(1, OS_D, 8'h03, 16'h0, 10'h31B, 1, 1));
        vecs.push_back(mk(1, OS_I, 8'h00, 16'h0, 10'h305, 0, 0));
        vecs.push_back(mk(1, OS_I, 8'h00, 16'h0, 10'h296, 1, 0));
        // /S/, D28.5 x3, /T/, /R/ x2, all at RD-
        vecs.push_back(mk(1, OS_S, 8'h00, 16'h0, 10'h368, 1, 0));
        vecs.push_back(mk(1, OS_D, 8'hBC, 16'h0, 10'h0EA, 1, 0));
        vecs.push_back(mk(1, OS_D, 8'hBC, 16'h0, 10'h0EA, 1, 0));
        vecs.push_back(mk(1, OS_D, 8'hBC, 16'h0, 10'h0EA, 1, 0));
        vecs.push_back(mk(1, OS_T, 8'h00, 16'h0, 10'h2E8, 1, 0));
        vecs.push_back(mk(1, OS_R, 8'h00, 16'h0, 10'h3A8, 1, 0));
        vecs.push_back(mk(1, OS_R, 8'h00, 16'h0, 10'h3A8, 1, 0));
        // Invalid and /V/ in both columns; the K codes again at RD+
        vecs.push_back(mk(1, 7'h7F, 8'h00, 16'h0, 10'h1E8, 1, 0));
        vecs.push_back(mk(1, OS_V,  8'h00, 16'h0, 10'h1E8, 1, 0));
        vecs.push_back(mk(1, OS_D,  8'h03, 16'h0, 10'h31B, 1, 1));
        vecs.push_back(mk(1, 7'h00, 8'h00, 16'h0, 10'h217, 1, 1));
        vecs.push_back(mk(1, OS_R,  8'h00, 16'h0, 10'h057, 1, 1));
        vecs.push_back(mk(1, OS_T,  8'h00, 16'h0, 10'h117, 1, 1));
        vecs.push_back(mk(1, OS_S,  8'h00, 16'h0, 10'h097, 1, 1));
        vecs.push_back(mk(1, OS_D,  8'h03, 16'h0, 10'h314, 1, 0));
        // D.x.7: A7 for D17.7 at RD- and D11.7 at RD+, P7 for D3.7 in both columns
        vecs.push_back(mk(1, OS_D, 8'hF1, 16'h0, 10'h237, 1, 1));
        vecs.push_back(mk(1, OS_D, 8'hEB, 16'h0, 10'h348, 1, 0));
        vecs.push_back(mk(1, OS_D, 8'hE3, 16'h0, 10'h31E, 1, 1));
        vecs.push_back(mk(1, OS_D, 8'hE3, 16'h0, 10'h311, 1, 0));
        // /C1/ then /C2/ with cfg 01A0. While indicate=0, tx_o_set is junk and
        // must be ignored. The second set changes cfg after CONF_A, and the
        // latched value must still be sent.
        vecs.push_back(mk(1, OS_C,  8'h00, CFG,      10'h0FA, 0, 1));
        vecs.push_back(mk(1, 7'h7F, 8'h00, CFG,      10'h2AA, 0, 1));
        vecs.push_back(mk(1, 7'h7F, 8'h00, CFG,      10'h18A, 0, 0));
        vecs.push_back(mk(1, 7'h7F, 8'h00, CFG,      10'h1D4, 1, 0));
        vecs.push_back(mk(1, OS_C,  8'h00, CFG,      10'h0FA, 0, 1));
        vecs.push_back(mk(1, OS_D,  8'h55, 16'hFFFF, 10'h125, 0, 0));
        vecs.push_back(mk(1, OS_D,  8'h55, 16'hFFFF, 10'h27A, 0, 1));
        vecs.push_back(mk(1, OS_D,  8'h55, 16'hFFFF, 10'h22B, 1, 1));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of /C/ must restore RD-, indicate and the C1 toggle.
        // First send /C1/ from RD+, so that the next /C/ would use C2.
        apply(mk(1, OS_C,  8'h00, CFG, 10'h305, 0, 0), "c1_a");
        apply(mk(1, OS_I,  8'h00, CFG, 10'h2AA, 0, 0), "c1_b");
        apply(mk(1, OS_I,  8'h00, CFG, 10'h27A, 0, 1), "c1_c");
        apply(mk(1, OS_I,  8'h00, CFG, 10'h22B, 1, 1), "c1_d");
        apply(mk(1, OS_C,  8'h00, CFG, 10'h305, 0, 0), "c2_a");
        apply(mk(0, OS_C,  8'h00, CFG, 10'h000, 1, 0), "rst_in_conf_b");
        apply(mk(1, OS_C,  8'h00, CFG, 10'h0FA, 0, 1), "post_rst_a");
        apply(mk(1, OS_I,  8'h00, CFG, 10'h2AA, 0, 1), "post_rst_c1");
        apply(mk(1, OS_I,  8'h00, CFG, 10'h18A, 0, 0), "post_rst_c");
        apply(mk(1, OS_I,  8'h00, CFG, 10'h1D4, 1, 0), "post_rst_d");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
